// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: SPI responder; oversamples sclk/ss/mosi in pclk, deserialises mosi, serialises a buffered tx word.
// Optional SPI_SLAVE_UNDERRUN_EN adds a sticky tx underrun flag with clear input.
module spi_slave_shifter #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsbfe_i,
  input  logic              sclk_i,
  input  logic              ss_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_load_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic              tx_underrun_o,
  input  logic              tx_underrun_clr_i
`endif
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sclk_s, ss_s, mosi_s;
  logic sclk_d, ss_d;
  logic cpol_q, cpha_q, lsbfe_q;
  logic [DATA_W-1:0] tx_buf, tx_sr, rx_sr, tx_word;
  logic [CW-1:0] bit_cnt;
  logic sclk_q, ss_q, mosi_q, sclk_rise, sclk_fall, sample_edge, shift_edge, ss_fall, first_bit;
  always_comb begin
    sclk_q      = sclk_s[SYNC_STAGES-1];
    ss_q        = ss_s[SYNC_STAGES-1];
    mosi_q      = mosi_s[SYNC_STAGES-1];
    sclk_rise   = sclk_q & ~sclk_d;
    sclk_fall   = ~sclk_q & sclk_d;
    sample_edge = (cpol_q == cpha_q) ? sclk_rise : sclk_fall;
    shift_edge  = (cpol_q == cpha_q) ? sclk_fall : sclk_rise;
    ss_fall     = ~ss_q & ss_d;
    // an empty buffer is bypassed by a coincident load, else the frame sends all ones
    tx_word     = !tx_ready_o ? tx_buf : tx_load_i ? tx_data_i : '1;
    first_bit   = lsbfe_i ? tx_word[0] : tx_word[DATA_W-1];
  end
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      sclk_s <= '0;
      ss_s   <= '1;
      mosi_s <= '0;
      sclk_d <= 1'b0;
      ss_d   <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk_i};
      ss_s   <= {ss_s[SYNC_STAGES-2:0], ss_i};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi_i};
      sclk_d <= sclk_q;
      ss_d   <= ss_q;
    end
  end
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state      <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsbfe_q    <= 1'b0;
      tx_buf     <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      miso_o     <= 1'b0;
      miso_oe_o  <= 1'b0;
      tx_ready_o <= 1'b1;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
      tx_underrun_o <= 1'b0;
`endif
    end else begin
      rx_valid_o <= 1'b0;
      if (tx_load_i) tx_buf <= tx_data_i;
      tx_ready_o <= (state == LOAD) ? !(tx_load_i && !tx_ready_o) : tx_ready_o && !tx_load_i;
`ifdef SPI_SLAVE_UNDERRUN_EN
      tx_underrun_o <= (state == LOAD && tx_ready_o && !tx_load_i) ? 1'b1 :
                       tx_underrun_clr_i ? 1'b0 : tx_underrun_o;
`endif
      case (state)
        IDLE: if (ss_fall) state <= LOAD;
        LOAD: begin
          cpol_q    <= cpol_i;
          cpha_q    <= cpha_i;
          lsbfe_q   <= lsbfe_i;
          tx_sr     <= tx_word;
          miso_o    <= first_bit;
          bit_cnt   <= '0;
          busy_o    <= 1'b1;
          miso_oe_o <= 1'b1;
          state     <= ACTIVE;
        end
        ACTIVE: begin
          if (bit_cnt == LAST) begin
            rx_data_o  <= rx_sr;
            rx_valid_o <= 1'b1;
            state      <= ss_q ? IDLE : LOAD;
            busy_o     <= !ss_q;
            miso_oe_o  <= !ss_q;
            miso_o     <= ss_q ? 1'b0 : miso_o;
          end else if (ss_q) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            miso_oe_o <= 1'b0;
            miso_o    <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_sr   <= lsbfe_q ? {mosi_q, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], mosi_q};
              bit_cnt <= bit_cnt + 1'b1;
            end
            // shift edges before the first sample are either the cpha=1 lead (bit already out) or a prior frame's trail
            if (shift_edge && |bit_cnt) begin
              tx_sr  <= lsbfe_q ? tx_sr >> 1 : tx_sr << 1;
              miso_o <= lsbfe_q ? tx_sr[1] : tx_sr[DATA_W-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_shifter.sv
// tb_spi_slave_shifter: SPI master model driving spi_slave_shifter; rx words checked through a scoreboard queue.
module tb_spi_slave_shifter;
  logic pclk = 1'b0, preset = 1'b1;
  logic cpol_i = 1'b0, cpha_i = 1'b0, lsbfe_i = 1'b0;
  logic sclk_i = 1'b0, ss_i = 1'b1, mosi_i = 1'b0;
  logic miso_o, miso_oe_o, tx_ready_o, rx_valid_o, busy_o;
  logic [7:0] tx_data_i = '0, rx_data_o;
  logic tx_load_i = 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic tx_underrun_o, tx_underrun_clr_i = 1'b0;
`endif
  int vectors = 0, miscompares = 0;
  logic [7:0] rxq[$];
  logic [7:0] exp_rx;
  logic m_cpol, m_cpha, m_lsb;

  spi_slave_shifter #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .pclk(pclk), .preset(preset), .cpol_i(cpol_i), .cpha_i(cpha_i), .lsbfe_i(lsbfe_i),
    .sclk_i(sclk_i), .ss_i(ss_i), .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe_o(miso_oe_o),
    .tx_data_i(tx_data_i), .tx_load_i(tx_load_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .busy_o(busy_o)
`ifdef SPI_SLAVE_UNDERRUN_EN
    , .tx_underrun_o(tx_underrun_o), .tx_underrun_clr_i(tx_underrun_clr_i)
`endif
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (!preset && rx_valid_o) begin
      vectors++;
      if (rxq.size() == 0) begin
        miscompares++;
        $display("FAIL rx_unexpected: rx_valid_o with data %h, no word expected", rx_data_o);
      end else begin
        exp_rx = rxq.pop_front();
        if (rx_data_o !== exp_rx) begin
          miscompares++;
          $display("FAIL rx_data: got %h expected %h", rx_data_o, exp_rx);
        end
      end
    end
  end

  task automatic half();
    repeat (4) @(posedge pclk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge pclk);
    tx_data_i = d;
    tx_load_i = 1'b1;
    @(negedge pclk);
    tx_load_i = 1'b0;
  endtask

  task automatic start(input logic cpol, input logic cpha, input logic lsb);
    m_cpol = cpol; m_cpha = cpha; m_lsb = lsb;
    cpol_i = cpol; cpha_i = cpha; lsbfe_i = lsb;
    sclk_i = cpol;
    half();
    ss_i = 1'b0;
    half();
  endtask

  task automatic bits(input int n, input logic [7:0] mo, output logic [7:0] mi);
    int idx;
    mi = '0;
    if (n == 8) rxq.push_back(mo);
    for (int i = 0; i < n; i++) begin
      idx = m_lsb ? i : 7 - i;
      if (!m_cpha) begin
        mosi_i = mo[idx];
        half();
        sclk_i = ~m_cpol;
        mi[idx] = miso_o;
        half();
        sclk_i = m_cpol;
      end else begin
        half();
        sclk_i = ~m_cpol;
        mosi_i = mo[idx];
        half();
        sclk_i = m_cpol;
        mi[idx] = miso_o;
      end
    end
  endtask

  task automatic stop();
    half();
    ss_i = 1'b1;
    half();
    half();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge pclk);
    #1;
    vectors += 6;
    if (miso_o !== 1'b0) begin miscompares++; $display("FAIL reset_miso: got %b expected 0", miso_o); end
    if (miso_oe_o !== 1'b0) begin miscompares++; $display("FAIL reset_oe: got %b expected 0", miso_oe_o); end
    if (tx_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", tx_ready_o); end
    if (rx_data_o !== 8'h00) begin miscompares++; $display("FAIL reset_rx: got %h expected 00", rx_data_o); end
    if (rx_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", rx_valid_o); end
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    preset = 1'b0;
    repeat (3) @(posedge pclk);
  endtask

  task automatic test_mode0();
    logic [7:0] mi;
    load(8'hA5);
    #1;
    vectors++;
    if (tx_ready_o !== 1'b0) begin miscompares++; $display("FAIL mode0_ready_after_load: got %b expected 0", tx_ready_o); end
    start(1'b0, 1'b0, 1'b0);
    vectors += 2;
    if (busy_o !== 1'b1 || miso_oe_o !== 1'b1) begin miscompares++; $display("FAIL mode0_busy_oe: got %b%b expected 11", busy_o, miso_oe_o); end
    if (tx_ready_o !== 1'b1) begin miscompares++; $display("FAIL mode0_ready_after_load_state: got %b expected 1", tx_ready_o); end
    bits(8, 8'h3C, mi);
    stop();
    vectors += 2;
    if (mi !== 8'hA5) begin miscompares++; $display("FAIL mode0_miso: got %h expected a5", mi); end
    if (busy_o !== 1'b0 || miso_oe_o !== 1'b0) begin miscompares++; $display("FAIL mode0_idle: got %b%b expected 00", busy_o, miso_oe_o); end
  endtask

  task automatic test_modes();
    logic [7:0] mi;
    for (int m = 1; m < 4; m++) begin
      load(8'h5A);
      start(m[1], m[0], 1'b0);
      // mode inputs change mid-frame; the latched mode must hold
      if (m == 3) begin cpol_i = 1'b0; cpha_i = 1'b0; lsbfe_i = 1'b1; end
      bits(8, 8'hC3, mi);
      stop();
      vectors++;
      if (mi !== 8'h5A) begin miscompares++; $display("FAIL mode%0d_miso: got %h expected 5a", m, mi); end
    end
  endtask

  task automatic test_lsbfe();
    logic [7:0] mi;
    load(8'h01);
    start(1'b0, 1'b0, 1'b1);
    vectors++;
    if (miso_o !== 1'b1) begin miscompares++; $display("FAIL lsb_first_bit: got %b expected 1", miso_o); end
    bits(8, 8'h80, mi);
    stop();
    vectors++;
    if (mi !== 8'h01) begin miscompares++; $display("FAIL lsb_miso: got %h expected 01", mi); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1, m2;
    load(8'h11);
    fork
      begin
        start(1'b0, 1'b0, 1'b0);
        bits(8, 8'hE7, m1);
        bits(8, 8'h18, m2);
        stop();
      end
      begin
        int t;
        t = 0;
        while (!(busy_o && tx_ready_o) && t < 400) begin @(posedge pclk); t++; end
        vectors++;
        if (t >= 400) begin miscompares++; $display("FAIL b2b_wait_ready: got timeout expected busy with empty buffer"); end
        else load(8'h22);
      end
    join
    vectors += 2;
    if (m1 !== 8'h11) begin miscompares++; $display("FAIL b2b_first: got %h expected 11", m1); end
    if (m2 !== 8'h22) begin miscompares++; $display("FAIL b2b_second: got %h expected 22", m2); end
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    load(8'h99);
    start(1'b0, 1'b0, 1'b0);
    bits(4, 8'hF0, mi);
    half();
    ss_i = 1'b1;
    repeat (4) @(posedge pclk);
    #1;
    vectors++;
    if (busy_o !== 1'b0 || miso_oe_o !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got %b%b expected 00", busy_o, miso_oe_o); end
    half();
    load(8'h6D);
    start(1'b0, 1'b1, 1'b0);
    bits(8, 8'h4B, mi);
    stop();
    vectors++;
    if (mi !== 8'h6D) begin miscompares++; $display("FAIL abort_next_miso: got %h expected 6d", mi); end
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
`ifdef SPI_SLAVE_UNDERRUN_EN
    vectors++;
    if (tx_underrun_o !== 1'b0) begin miscompares++; $display("FAIL underrun_pre: got %b expected 0", tx_underrun_o); end
`endif
    start(1'b0, 1'b0, 1'b0);
    bits(8, 8'h55, mi);
    stop();
    vectors++;
    if (mi !== 8'hFF) begin miscompares++; $display("FAIL underrun_miso: got %h expected ff", mi); end
`ifdef SPI_SLAVE_UNDERRUN_EN
    vectors++;
    if (tx_underrun_o !== 1'b1) begin miscompares++; $display("FAIL underrun_set: got %b expected 1", tx_underrun_o); end
    @(negedge pclk);
    tx_underrun_clr_i = 1'b1;
    @(negedge pclk);
    tx_underrun_clr_i = 1'b0;
    vectors++;
    if (tx_underrun_o !== 1'b0) begin miscompares++; $display("FAIL underrun_clr: got %b expected 0", tx_underrun_o); end
`endif
  endtask

  task automatic test_preset_midframe();
    logic [7:0] mi;
    load(8'h3E);
    start(1'b0, 1'b0, 1'b0);
    bits(3, 8'hAA, mi);
    preset = 1'b1;
    #1;
    vectors += 3;
    if (busy_o !== 1'b0 || miso_oe_o !== 1'b0) begin miscompares++; $display("FAIL preset_idle: got %b%b expected 00", busy_o, miso_oe_o); end
    if (miso_o !== 1'b0) begin miscompares++; $display("FAIL preset_miso: got %b expected 0", miso_o); end
    if (tx_ready_o !== 1'b1) begin miscompares++; $display("FAIL preset_ready: got %b expected 1", tx_ready_o); end
    ss_i = 1'b1;
    sclk_i = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    preset = 1'b0;
    half();
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_lsbfe();
    test_back_to_back();
    test_abort();
    test_underrun();
    test_preset_midframe();
    vectors++;
    if (rxq.size() != 0) begin miscompares++; $display("FAIL rx_missing: got %0d words outstanding expected 0", rxq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
